neuron: RTL and testbench
=========================

# neuron

Parametrised single-neuron compute block: a trainable weighted-sum unit with a selectable activation and built-in weight update. It generalises the fixed two-input associate/heaviside pairing: N inputs, a runtime-selected Heaviside or clamped-ReLU activation, and an on-chip gradient step with saturating weights. A sequential multiply-accumulate (one product per cycle) feeds the activation, and back-propagated feedback goes upstream. It sits between an argument producer and an error source in a layered network, using stb/rdy handshakes on every channel.

## Interface
- N, 4, number of inputs (≥1)
- RATE, 4, learning-rate right-shift applied to weight deltas (0–15)
- ACT, 0, activation: 0 = Heaviside, 1 = clamped ReLU
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  training enable, sampled on the result handshake
- arg_stb  in  1  argument valid
- arg_dat  in  N×8  unsigned Q0.8 inputs x[i]
- arg_rdy  out  1  argument accept
- res_stb  out  1  result valid
- res_dat  out  8  unsigned Q0.8 activation
- res_rdy  in  1  result accept
- err_stb  in  1  error valid
- err_dat  in  16  signed Q8.8 error e
- err_rdy  out  1  error accept
- fbk_stb  out  1  feedback valid
- fbk_dat  out  N×16  signed Q8.8 feedback per input
- fbk_rdy  in  1  feedback accept

## Operation
- State: weights w[0..N-1] and bias b, all signed Q8.8 (16 bit), plus latched x[] and e.
- FSM states: IDLE, MAC, RESULT, ERROR, UPDATE, FEEDBACK.
- IDLE: arg_rdy=1. On arg_stb&arg_rdy, latch arg_dat, set acc = sign-extend(b)<<8, go to MAC.
- MAC: N cycles. Cycle i performs acc += x[i]*w[i]. acc is signed Q8.16, 24+clog2(N+1) bits, with no overflow possible. Then go to RESULT.
- Activation:
  - ACT=0: res_dat = (acc ≥ 0) ? 8'hFF : 8'h00.
  - ACT=1: res_dat = clamp(acc>>>8, 0, 255).
- RESULT: res_stb=1, res_dat held stable. On res_stb&res_rdy: go to ERROR if en=1, else IDLE.
- ERROR: err_rdy=1. On handshake, latch e and go to UPDATE.
- UPDATE: N+1 cycles, index i = 0..N.
  - For i<N: fbk[i] = trunc16((e*w[i])>>>8), using the pre-update w[i]; then w[i] = sat16(w[i] + ((e*x[i])>>>(8+RATE))).
  - For i=N: b = sat16(b + (e>>>RATE)).
  - sat16 clamps to [-32768, 32767]. Shifts are arithmetic.
- FEEDBACK: fbk_stb=1, fbk_dat held stable. On fbk_stb&fbk_rdy, go to IDLE.
- Only one transaction is in flight. arg_rdy is 0 in every state except IDLE.
- en changes outside the RESULT handshake cycle have no effect on the current transaction.

## Timing
- Reset values:
  - State IDLE; all w and b = 0.
  - arg_rdy=0 during the reset cycle, 1 on the first cycle after.
  - res_stb=0, err_rdy=0, fbk_stb=0; res_dat=0, fbk_dat=0.
- Reset mid-operation (any state) aborts the transaction and clears weights. No stb is asserted on the next cycle.
- Argument accepted at edge T: res_stb rises at T+N+1, giving N+1 cycles arg→res with no stall.
- Error accepted at edge U: fbk_stb rises at U+N+2 (N+1 update cycles plus the FEEDBACK entry edge).
- Back-to-back: the next argument is accepted no earlier than the cycle after the res handshake (en=0) or after the fbk handshake (en=1).
- All stb outputs are registered and stay high until the matching rdy. Data is stable while stb is high.
- rdy outputs never depend combinationally on stb inputs.

## Test plan
- Reset, then arg_dat = all 8'h80, ACT=0, en=0 → acc=0 → res_dat=8'hFF at T+N+1; arg_rdy returns high the cycle after the handshake; err_rdy never asserts.
- ACT=0, en=1, RATE=0, arg = all 8'hFF, err=16'h0100 → fbk_dat all 0 (pre-update weights). Afterwards every w[i]=16'h00FF and b=16'h0100. A second error 16'h0100 on the same args → fbk_dat all 16'h00FF.
- ACT=1 after the previous training, arg = all 8'hFF → res_dat = clamp → 8'hFF. Then train with err=16'hFF00 (−1.0) twice → weights back near 0 and negative; next pass res_dat=8'h00.
- Saturation: RATE=0, err=16'h7FFF, arg=8'hFF, repeated 3× → all w[i] and b = 16'h7FFF exactly, with no wrap.
- Backpressure: hold res_rdy=0 for 5 cycles, then fbk_rdy=0 for 5 cycles → res_dat/fbk_dat stable, stb held high, arg_rdy=0 throughout. Toggling en during the RESULT stall affects only the value at the handshake edge.
- Reset asserted during MAC cycle 2 → next cycle all stb=0, state IDLE, weights 0. A subsequent arg with all 8'h80 yields 8'hFF (ACT=0).

Source files
------------

// File: rtl/neuron.sv
// Trainable N-input neuron: sequential weighted sum, Heaviside or clamped-ReLU
// activation, and an on-chip gradient step with saturating Q8.8 weights.
module neuron #(
    parameter int N    = 4,
    parameter int RATE = 4,
    parameter int ACT  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            arg_stb,
    input  logic [N*8-1:0]  arg_dat,
    output logic            arg_rdy,
    output logic            res_stb,
    output logic [7:0]      res_dat,
    input  logic            res_rdy,
    input  logic            err_stb,
    input  logic [15:0]     err_dat,
    output logic            err_rdy,
    output logic            fbk_stb,
    output logic [N*16-1:0] fbk_dat,
    input  logic            fbk_rdy
);
    localparam int IW = $clog2(N + 1);
    localparam int AW = 24 + IW;

    typedef enum logic [2:0] {IDLE, MAC, RESULT, ERROR, UPDATE, FEEDBACK} state_t;

    state_t               state_q;
    logic [IW-1:0]        idx_q;
    logic [7:0]           x_q   [N];
    logic signed [15:0]   w_q   [N];
    logic signed [15:0]   fbk_q [N];
    logic signed [15:0]   b_q;
    logic signed [15:0]   e_q;
    logic signed [AW-1:0] acc_q;
    logic [7:0]           res_q;
    logic                 arg_rdy_q;
    logic                 res_stb_q;
    logic                 err_rdy_q;
    logic                 fbk_stb_q;

    logic [7:0]           x_sel;
    logic signed [15:0]   w_sel;
    logic signed [24:0]   prod_xw;
    logic signed [24:0]   prod_ex;
    logic signed [24:0]   delta;
    logic signed [31:0]   prod_ew;
    logic signed [AW-1:0] acc_d;
    logic signed [15:0]   w_d;
    logic signed [15:0]   b_d;
    logic signed [15:0]   fbk_d;

    function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
        if (v > 26'sd32767)       return 16'sh7FFF;
        else if (v < -26'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    function automatic logic [7:0] activate(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> 8;
        if (ACT == 0)          return a[AW-1] ? 8'h00 : 8'hFF;
        else if (s[AW-1])      return 8'h00;
        else if (s > AW'(255)) return 8'hFF;
        else                   return s[7:0];
    endfunction

    // One shared x/w lane selected by idx_q serves both the MAC and the update walk.
    always_comb begin
        x_sel = 8'h00;
        w_sel = 16'sh0000;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                x_sel = x_q[i];
                w_sel = w_q[i];
            end
        end
        prod_xw = 25'($signed({1'b0, x_sel})) * 25'(w_sel);
        prod_ex = 25'(e_q) * 25'($signed({1'b0, x_sel}));
        delta   = prod_ex >>> (8 + RATE);
        prod_ew = 32'(e_q) * 32'(w_sel);
        acc_d   = acc_q + AW'(prod_xw);
        w_d     = sat16(26'(w_sel) + 26'(delta));
        b_d     = sat16(26'(b_q) + 26'(e_q >>> RATE));
        fbk_d   = 16'(prod_ew >>> 8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            e_q       <= '0;
            res_q     <= '0;
            arg_rdy_q <= 1'b0;
            res_stb_q <= 1'b0;
            err_rdy_q <= 1'b0;
            fbk_stb_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x_q[i]   <= '0;
                w_q[i]   <= '0;
                fbk_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    arg_rdy_q <= 1'b1;
                    if (arg_stb && arg_rdy_q) begin
                        arg_rdy_q <= 1'b0;
                        for (int i = 0; i < N; i++) x_q[i] <= arg_dat[i*8 +: 8];
                        acc_q   <= {{IW{b_q[15]}}, b_q, 8'h00};
                        idx_q   <= '0;
                        state_q <= MAC;
                    end
                end
                // Indices 0..N-1 accumulate; index N registers the activation.
                MAC: begin
                    if (idx_q == IW'(N)) begin
                        res_q     <= activate(acc_q);
                        res_stb_q <= 1'b1;
                        state_q   <= RESULT;
                    end else begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + IW'(1);
                    end
                end
                RESULT: begin
                    if (res_rdy) begin
                        res_stb_q <= 1'b0;
                        if (en) begin
                            err_rdy_q <= 1'b1;
                            state_q   <= ERROR;
                        end else begin
                            arg_rdy_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                ERROR: begin
                    if (err_stb) begin
                        err_rdy_q <= 1'b0;
                        e_q       <= $signed(err_dat);
                        idx_q     <= '0;
                        state_q   <= UPDATE;
                    end
                end
                UPDATE: begin
                    if (idx_q == IW'(N)) begin
                        b_q     <= b_d;
                        state_q <= FEEDBACK;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (idx_q == IW'(i)) begin
                                w_q[i]   <= w_d;
                                fbk_q[i] <= fbk_d;
                            end
                        end
                        idx_q <= idx_q + IW'(1);
                    end
                end
                FEEDBACK: begin
                    if (!fbk_stb_q) begin
                        fbk_stb_q <= 1'b1;
                    end else if (fbk_rdy) begin
                        fbk_stb_q <= 1'b0;
                        arg_rdy_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arg_rdy = arg_rdy_q;
    assign res_stb = res_stb_q;
    assign res_dat = res_q;
    assign err_rdy = err_rdy_q;
    assign fbk_stb = fbk_stb_q;

    always_comb begin
        fbk_dat = '0;
        for (int i = 0; i < N; i++) fbk_dat[i*16 +: 16] = fbk_q[i];
    end
endmodule

// File: tb/tb_neuron.sv
// Scoreboard bench for neuron: two instances (Heaviside/RATE=0 and ReLU/RATE=2)
// share stimulus; an integer reference model predicts results and feedback.
`timescale 1ns/1ps
module tb_neuron;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, arg_stb, res_rdy, err_stb, fbk_rdy;
    logic [31:0] arg_dat;
    logic [15:0] err_dat;
    logic        arg_rdy0, res_stb0, err_rdy0, fbk_stb0;
    logic        arg_rdy1, res_stb1, err_rdy1, fbk_stb1;
    logic [7:0]  res_dat0, res_dat1;
    logic [63:0] fbk_dat0, fbk_dat1;

    neuron #(.N(N), .RATE(0), .ACT(0)) u0 (
        .clk(clk), .rst(rst), .en(en),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy0),
        .res_stb(res_stb0), .res_dat(res_dat0), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy0),
        .fbk_stb(fbk_stb0), .fbk_dat(fbk_dat0), .fbk_rdy(fbk_rdy)
    );

    neuron #(.N(N), .RATE(2), .ACT(1)) u1 (
        .clk(clk), .rst(rst), .en(en),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy1),
        .res_stb(res_stb1), .res_dat(res_dat1), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy1),
        .fbk_stb(fbk_stb1), .fbk_dat(fbk_dat1), .fbk_rdy(fbk_rdy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int w_m [2][N];
    int b_m [2];
    logic [63:0] q_res0[$], q_res1[$], q_fbk0[$], q_fbk1[$];
    bit          prev [4];
    logic [63:0] cur  [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no handshake, expected one within 50 cycles (t=%0t)", name, $time);
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int rate_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    // Reference: value = bias + sum x*w in Q8.16, then the instance's activation.
    function automatic logic [7:0] model_res(input int k, input logic [31:0] a);
        int acc;
        acc = b_m[k] * 256;
        for (int i = 0; i < N; i++) acc += int'(a[8*i +: 8]) * w_m[k][i];
        if (k == 0) return (acc >= 0) ? 8'hFF : 8'h00;
        return 8'(clamp(acc >>> 8, 0, 255));
    endfunction

    task automatic model_train(input int k, input logic [31:0] a, input logic [15:0] e,
                               output logic [63:0] fb);
        int ei, p;
        ei = int'($signed(e));
        fb = '0;
        for (int i = 0; i < N; i++) begin
            p = (ei * w_m[k][i]) >>> 8;
            fb[16*i +: 16] = p[15:0];
            w_m[k][i] = clamp(w_m[k][i] + ((ei * int'(a[8*i +: 8])) >>> (8 + rate_of(k))),
                              -32768, 32767);
        end
        b_m[k] = clamp(b_m[k] + (ei >>> rate_of(k)), -32768, 32767);
    endtask

    task automatic mon(input int c, input logic stb, input logic [63:0] dat, input string name);
        logic [63:0] v;
        bit ok;
        if (stb) begin
            if (!prev[c]) begin
                ok = 1'b1;
                v  = '0;
                case (c)
                    0: if (q_res0.size() > 0) v = q_res0.pop_front(); else ok = 1'b0;
                    1: if (q_res1.size() > 0) v = q_res1.pop_front(); else ok = 1'b0;
                    2: if (q_fbk0.size() > 0) v = q_fbk0.pop_front(); else ok = 1'b0;
                    default: if (q_fbk1.size() > 0) v = q_fbk1.pop_front(); else ok = 1'b0;
                endcase
                if (!ok) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s: got unexpected output %h, expected none queued", name, dat);
                    v = dat;
                end
                cur[c] = v;
            end
            chk(name, dat, cur[c]);
        end
        prev[c] = stb;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) prev[c] = 1'b0;
        end else begin
            mon(0, res_stb0, 64'(res_dat0), "res_dat_heaviside");
            mon(1, res_stb1, 64'(res_dat1), "res_dat_relu");
            mon(2, fbk_stb0, fbk_dat0, "fbk_dat_rate0");
            mon(3, fbk_stb1, fbk_dat1, "fbk_dat_rate2");
        end
    end

    task automatic send_arg(input logic [31:0] a);
        int k;
        q_res0.push_back(64'(model_res(0, a)));
        q_res1.push_back(64'(model_res(1, a)));
        arg_dat = a;
        arg_stb = 1'b1;
        k = 0;
        while (!arg_rdy0 && k < 50) begin @(negedge clk); k++; end
        if (!arg_rdy0) begin timeout("arg_rdy"); arg_stb = 1'b0; return; end
        @(posedge clk);
        #1 arg_stb = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!res_stb0 && k < 50);
        chk("arg_to_res_latency", 64'(k - 1), 64'(N + 1));
    endtask

    task automatic take_res(input int hold, input logic en_v);
        for (int c = 0; c < hold; c++) begin
            en = 1'($urandom_range(0, 1));
            chk("res_stb_held", 64'(res_stb0), 64'(1));
            chk("arg_rdy_low_in_result", 64'(arg_rdy0), 64'(0));
            @(negedge clk);
        end
        en = en_v;
        res_rdy = 1'b1;
        @(posedge clk);
        #1 res_rdy = 1'b0;
        en = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("arg_rdy_after_res", 64'(arg_rdy0), 64'(!en_v));
        chk("err_rdy_after_res", 64'(err_rdy0), 64'(en_v));
    endtask

    task automatic send_err(input logic [15:0] e, input logic [31:0] a);
        logic [63:0] fb;
        int k;
        model_train(0, a, e, fb);
        q_fbk0.push_back(fb);
        model_train(1, a, e, fb);
        q_fbk1.push_back(fb);
        err_dat = e;
        err_stb = 1'b1;
        k = 0;
        while (!err_rdy0 && k < 50) begin @(negedge clk); k++; end
        if (!err_rdy0) begin timeout("err_rdy"); err_stb = 1'b0; return; end
        @(posedge clk);
        #1 err_stb = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!fbk_stb0 && k < 50);
        chk("err_to_fbk_latency", 64'(k - 1), 64'(N + 2));
    endtask

    task automatic take_fbk(input int hold);
        for (int c = 0; c < hold; c++) begin
            chk("fbk_stb_held", 64'(fbk_stb0), 64'(1));
            chk("arg_rdy_low_in_feedback", 64'(arg_rdy0), 64'(0));
            @(negedge clk);
        end
        fbk_rdy = 1'b1;
        @(posedge clk);
        #1 fbk_rdy = 1'b0;
        @(negedge clk);
        chk("arg_rdy_after_fbk", 64'(arg_rdy0), 64'(1));
    endtask

    task automatic txn(input logic [31:0] a, input logic en_v, input logic [15:0] e,
                       input int hres, input int hfbk);
        send_arg(a);
        take_res(hres, en_v);
        if (en_v) begin
            send_err(e, a);
            take_fbk(hfbk);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_res_stb"}, 64'(res_stb0), 64'(0));
        chk({tag, "_err_rdy"}, 64'(err_rdy0), 64'(0));
        chk({tag, "_fbk_stb"}, 64'(fbk_stb0), 64'(0));
        chk({tag, "_arg_rdy"}, 64'(arg_rdy0), 64'(0));
        chk({tag, "_res_dat"}, 64'(res_dat1), 64'(0));
        chk({tag, "_fbk_dat"}, fbk_dat0, 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected finish before 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; arg_stb = 1'b0; res_rdy = 1'b0;
        err_stb = 1'b0; fbk_rdy = 1'b0; arg_dat = '0; err_dat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("arg_rdy_after_reset", 64'(arg_rdy0), 64'(1));

        txn(32'h80808080, 1'b0, 16'h0000, 0, 0);
        txn(32'hFFFFFFFF, 1'b1, 16'h0100, 0, 0);
        txn(32'hFFFFFFFF, 1'b1, 16'h0100, 0, 0);
        txn(32'hFFFFFFFF, 1'b0, 16'h0000, 1, 0);
        txn(32'hFFFFFFFF, 1'b1, 16'hFF00, 0, 0);
        txn(32'hFFFFFFFF, 1'b1, 16'hFF00, 0, 0);
        txn(32'hFFFFFFFF, 1'b0, 16'h0000, 0, 0);
        repeat (3) txn(32'hFFFFFFFF, 1'b1, 16'h7FFF, 0, 0);
        txn(32'hFFFFFFFF, 1'b1, 16'h0100, 0, 0);
        txn(32'h20406080, 1'b1, 16'hC000, 5, 5);

        // Abort a transaction while the MAC is on its second product.
        arg_dat = 32'h12345678;
        arg_stb = 1'b1;
        while (!arg_rdy0) @(negedge clk);
        @(posedge clk);
        #1 arg_stb = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_quiet("mid_mac_reset");
        for (int k = 0; k < 2; k++) begin
            b_m[k] = 0;
            for (int i = 0; i < N; i++) w_m[k][i] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("arg_rdy_after_mid_reset", 64'(arg_rdy0), 64'(1));
        txn(32'h80808080, 1'b0, 16'h0000, 0, 0);

        for (int t = 0; t < 24; t++) begin
            logic [31:0] a;
            logic [15:0] e;
            a = $urandom();
            if ($urandom_range(0, 3) == 0) e = 16'($urandom());
            else e = 16'(int'($urandom_range(0, 2047)) - 1024);
            txn(a, 1'($urandom_range(0, 3) != 0), e,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        chk("res_queue_drained", 64'(q_res0.size() + q_res1.size()), 64'(0));
        chk("fbk_queue_drained", 64'(q_fbk0.size() + q_fbk1.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
